// File: rtl/thumb_fetch_pkg.sv
// Shared constants for the Thumb fetch stage: FSM encoding and 32-bit
// instruction prefix decode.
package thumb_fetch_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   localparam int unsigned HW_SLOTS = 4;

   // First-halfword [15:11] values that start a 32-bit Thumb instruction
   localparam logic [4:0] T32_PFX_A = 5'b11101;
   localparam logic [4:0] T32_PFX_B = 5'b11110;
   localparam logic [4:0] T32_PFX_C = 5'b11111;

   function automatic logic is_thumb32(input logic [15:0] hw);
      return (hw[15:11] == T32_PFX_A) || (hw[15:11] == T32_PFX_B) ||
             (hw[15:11] == T32_PFX_C);
   endfunction

endpackage

// File: rtl/fetch_hw_buffer.sv
// Four-entry halfword FIFO: up to two pushes and two pops per cycle, with a
// synchronous flush that wins over any push or pop in the same cycle.
module fetch_hw_buffer
   import thumb_fetch_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_i,
   input  logic [1:0]  push_n_i,
   input  logic [15:0] push_hw0_i,
   input  logic [15:0] push_hw1_i,
   input  logic [1:0]  pop_n_i,
   output logic [2:0]  count_o,
   output logic [15:0] head0_o,
   output logic [15:0] head1_o
);

   logic [15:0] mem_q [HW_SLOTS];
   logic [1:0]  rd_ptr_q;
   logic [1:0]  wr_ptr_q;
   logic [2:0]  count_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= 2'd0;
         wr_ptr_q <= 2'd0;
         count_q  <= 3'd0;
         for (int i = 0; i < HW_SLOTS; i++) mem_q[i] <= 16'h0000;
      end else if (flush_i) begin
         rd_ptr_q <= 2'd0;
         wr_ptr_q <= 2'd0;
         count_q  <= 3'd0;
      end else begin
         if (push_n_i != 2'd0) mem_q[wr_ptr_q] <= push_hw0_i;
         if (push_n_i == 2'd2) mem_q[wr_ptr_q + 2'd1] <= push_hw1_i;
         // 2-bit pointers wrap on their own at the buffer depth
         wr_ptr_q <= wr_ptr_q + push_n_i;
         rd_ptr_q <= rd_ptr_q + pop_n_i;
         count_q  <= count_q - {1'b0, pop_n_i} + {1'b0, push_n_i};
      end
   end

   assign count_o = count_q;
   assign head0_o = mem_q[rd_ptr_q];
   assign head1_o = mem_q[rd_ptr_q + 2'd1];

endmodule

// File: rtl/fetch_unit.sv
// Thumb instruction fetch: word fetches into a halfword prefetch buffer,
// 16/32-bit assembly, decode handshake, PC write-back and branch redirect.
module fetch_unit
   import thumb_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        branch_valid,
   input  logic [31:0] branch_target,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic        instr_is32,
   output logic [31:0] instr_addr,
   output logic        ld_pc,
   output logic [31:0] w_PC
);

   // Highest occupancy (in-flight word counted as two) that still fits a word
   localparam logic [3:0] ROOM_MAX = 4'(BUF_DEPTH - 2);

   logic [1:0]  state_q, state_d;
   logic [31:0] fetch_addr_q, fetch_addr_d;
   logic [31:0] head_addr_q, head_addr_d;
   logic        skip_lo_q, skip_lo_d;
   logic        drop_q, drop_d;
   logic        ld_pc_q, ld_pc_d;
   logic [31:0] w_pc_q, w_pc_d;

   logic [1:0]  push_n, pop_n;
   logic [15:0] push_hw0, push_hw1, head0, head1;
   logic [2:0]  buf_count;
   logic [3:0]  occ_now, occ_after;
   logic        head_is32, avail, issue;

   fetch_hw_buffer u_buf (
      .clk_i      (clk),
      .rst_ni     (rst),
      .flush_i    (branch_valid),
      .push_n_i   (push_n),
      .push_hw0_i (push_hw0),
      .push_hw1_i (push_hw1),
      .pop_n_i    (pop_n),
      .count_o    (buf_count),
      .head0_o    (head0),
      .head1_o    (head1)
   );

   assign head_is32   = is_thumb32(head0);
   assign avail       = head_is32 ? (buf_count >= 3'd2) : (buf_count >= 3'd1);
   assign instr_valid = avail && !branch_valid;
   assign issue       = instr_valid && instr_ready;
   assign pop_n       = issue ? (head_is32 ? 2'd2 : 2'd1) : 2'd0;

   assign instr      = !instr_valid ? 32'h0 :
                       head_is32    ? {head0, head1} : {16'h0000, head0};
   assign instr_is32 = instr_valid && head_is32;
   assign instr_addr = instr_valid ? head_addr_q : 32'h0;

   assign imem_req  = (state_q == S_REQ);
   assign imem_addr = fetch_addr_q;
   assign ld_pc     = ld_pc_q;
   assign w_PC      = w_pc_q;

   assign occ_now = {1'b0, buf_count} + ((state_q == S_WAIT) ? 4'd2 : 4'd0);

   always_comb begin
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      head_addr_d  = head_addr_q + {29'd0, pop_n, 1'b0};
      skip_lo_d    = skip_lo_q;
      drop_d       = drop_q;
      push_n       = 2'd0;
      push_hw0     = imem_rdata[15:0];
      push_hw1     = imem_rdata[31:16];
      ld_pc_d      = issue;
      w_pc_d       = issue ? head_addr_q + 32'd4 : w_pc_q;
      occ_after    = 4'd0;
      if (branch_valid) begin
         fetch_addr_d = branch_target & 32'hFFFF_FFFC;
         head_addr_d  = branch_target & 32'hFFFF_FFFE;
         skip_lo_d    = branch_target[1];
         ld_pc_d      = 1'b1;
         w_pc_d       = (branch_target & 32'hFFFF_FFFE) + 32'd4;
         // A word already granted belongs to the old stream and must be dropped
         case (state_q)
            S_REQ: begin
               if (imem_gnt) begin
                  state_d = S_WAIT;
                  drop_d  = 1'b1;
               end
            end
            S_WAIT: begin
               state_d = imem_rvalid ? S_REQ : S_WAIT;
               drop_d  = !imem_rvalid;
            end
            default: state_d = S_REQ;
         endcase
      end else begin
         case (state_q)
            S_IDLE: if (occ_now <= ROOM_MAX) state_d = S_REQ;
            S_REQ:  if (imem_gnt) state_d = S_WAIT;
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (drop_q) begin
                     drop_d = 1'b0;
                  end else begin
                     fetch_addr_d = fetch_addr_q + 32'd4;
                     if (skip_lo_q) begin
                        push_n    = 2'd1;
                        push_hw0  = imem_rdata[31:16];
                        skip_lo_d = 1'b0;
                     end else begin
                        push_n = 2'd2;
                     end
                  end
                  occ_after = {1'b0, buf_count} - {2'b00, pop_n} + {2'b00, push_n};
                  state_d   = (occ_after <= ROOM_MAX) ? S_REQ : S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         fetch_addr_q <= RESET_VECTOR & 32'hFFFF_FFFC;
         head_addr_q  <= RESET_VECTOR & 32'hFFFF_FFFE;
         skip_lo_q    <= RESET_VECTOR[1];
         drop_q       <= 1'b0;
         ld_pc_q      <= 1'b0;
         w_pc_q       <= 32'h0;
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         head_addr_q  <= head_addr_d;
         skip_lo_q    <= skip_lo_d;
         drop_q       <= drop_d;
         ld_pc_q      <= ld_pc_d;
         w_pc_q       <= w_pc_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder, scoreboard monitor on the decode
// and PC-write ports, and one task per scenario.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        branch_valid;
   logic [31:0] branch_target;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic        instr_is32;
   logic [31:0] instr_addr;
   logic        ld_pc;
   logic [31:0] w_PC;

   int checks   = 0;
   int failures = 0;

   // {is32, addr, instr}
   logic [64:0] exp_q[$];
   logic [31:0] mem [logic [31:0]];

   logic        rsp_pend = 1'b0;
   logic [31:0] rsp_addr = 32'h0;
   int          rsp_lat  = 0;
   logic [31:0] rv_addr  = 32'h0;
   int          lat_fixed = 0;
   bit          lat_rand  = 1'b0;
   bit          gnt_rand  = 1'b0;

   fetch_unit #(.RESET_VECTOR(32'h0000_0000), .BUF_DEPTH(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_gnt      (imem_gnt),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .instr_is32    (instr_is32),
      .instr_addr    (instr_addr),
      .ld_pc         (ld_pc),
      .w_PC          (w_PC)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- memory model ----------------
   function automatic logic [15:0] dflt_hw(input logic [31:0] a);
      return {3'b001, a[13:1]};
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {dflt_hw(a + 32'd2), dflt_hw(a)};
   endfunction

   function automatic logic [15:0] hw_at(input logic [31:0] a);
      logic [31:0] w;
      w = mem_word(a & 32'hFFFF_FFFC);
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   function automatic bit model_is32(input logic [15:0] h);
      return (h[15:11] == 5'b11101) || (h[15:11] == 5'b11110) || (h[15:11] == 5'b11111);
   endfunction

   task automatic push_stream(input logic [31:0] start, input int n);
      logic [31:0] a;
      logic [15:0] h0, h1;
      a = start & 32'hFFFF_FFFE;
      for (int i = 0; i < n; i++) begin
         h0 = hw_at(a);
         if (model_is32(h0)) begin
            h1 = hw_at(a + 32'd2);
            exp_q.push_back({1'b1, a, h0, h1});
            a = a + 32'd4;
         end else begin
            exp_q.push_back({1'b0, a, 16'h0000, h0});
            a = a + 32'd2;
         end
      end
   endtask

   // Responder: grant decided at negedge, data returned lat cycles later
   initial begin
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         imem_rvalid = 1'b0;
         if (rsp_pend) begin
            if (rsp_lat == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(rsp_addr);
               rv_addr     = rsp_addr;
               rsp_pend    = 1'b0;
            end else begin
               rsp_lat--;
            end
         end
         imem_gnt = 1'b0;
         if (rst && imem_req && !rsp_pend && (gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1)) begin
            imem_gnt = 1'b1;
            rsp_pend = 1'b1;
            rsp_addr = imem_addr;
            rsp_lat  = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
         end
      end
   end

   // Scoreboard monitor: issues, PC write strobe, request address stability
   initial begin
      logic [64:0] e;
      logic        exp_ld;
      logic [31:0] exp_w;
      logic        prev_hold;
      logic [31:0] prev_addr;
      exp_ld = 1'b0; exp_w = 32'h0; prev_hold = 1'b0; prev_addr = 32'h0;
      forever begin
         @(negedge clk); #4;
         if (!rst) begin
            exp_ld = 1'b0;
            prev_hold = 1'b0;
         end else begin
            checks++;
            if (ld_pc !== exp_ld || (exp_ld && w_PC !== exp_w)) begin
               failures++;
               $display("FAIL ld_pc: got ld_pc=%0b w_PC=%h, want ld_pc=%0b w_PC=%h",
                        ld_pc, w_PC, exp_ld, exp_w);
            end
            if (prev_hold) begin
               checks++;
               if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                  failures++;
                  $display("FAIL addr_hold: got req=%0b addr=%h, want req=1 addr=%h",
                           imem_req, imem_addr, prev_addr);
               end
            end
            prev_hold = imem_req && !imem_gnt && !branch_valid;
            prev_addr = imem_addr;
            exp_ld = 1'b0;
            if (branch_valid) begin
               exp_ld = 1'b1;
               exp_w  = (branch_target & 32'hFFFF_FFFE) + 32'd4;
            end else if (instr_valid && instr_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL issue_unexpected: got instr=%h addr=%h, want no issue",
                           instr, instr_addr);
               end else begin
                  e = exp_q.pop_front();
                  if ({instr_is32, instr_addr, instr} !== e) begin
                     failures++;
                     $display("FAIL issue: got is32=%0b addr=%h instr=%h, want is32=%0b addr=%h instr=%h",
                              instr_is32, instr_addr, instr, e[64], e[63:32], e[31:0]);
                  end
                  exp_ld = 1'b1;
                  exp_w  = e[63:32] + 32'd4;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_branch(input logic [31:0] t);
      @(negedge clk);
      branch_valid  = 1'b1;
      branch_target = t;
      @(negedge clk);
      branch_valid  = 1'b0;
   endtask

   task automatic drain(input int max_cycles, input bit rnd_ready);
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (exp_q.size() == 0 || n >= max_cycles) begin
            instr_ready = 1'b0;
            break;
         end
         instr_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         n++;
      end
   endtask

   task automatic wait_pend();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #4;
         if (rsp_pend) break;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #4;
      checks++;
      if ({imem_req, imem_addr, instr_valid, instr, instr_is32, instr_addr, ld_pc, w_PC} !== 132'h0) begin
         failures++;
         $display("FAIL reset_values: got req=%0b addr=%h v=%0b instr=%h is32=%0b iaddr=%h ld=%0b wpc=%h, want all 0",
                  imem_req, imem_addr, instr_valid, instr, instr_is32, instr_addr, ld_pc, w_PC);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk); #4;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         failures++;
         $display("FAIL first_fetch: got req=%0b addr=%h, want req=1 addr=00000000", imem_req, imem_addr);
      end
   endtask

   task automatic test_basic();
      push_stream(32'h0, 2);
      drain(50, 1'b0);
      checks++;
      if (exp_q.size() !== 0) begin
         failures++;
         $display("FAIL basic_drain: got %0d pending, want 0", exp_q.size());
      end
   endtask

   task automatic test_bl();
      do_branch(32'h200);
      push_stream(32'h200, 3);
      drain(50, 1'b0);
      checks++;
      if (exp_q.size() !== 0) begin
         failures++;
         $display("FAIL bl_drain: got %0d pending, want 0", exp_q.size());
      end
   endtask

   task automatic test_split();
      bit got304;
      bit early;
      got304 = 1'b0;
      early  = 1'b0;
      lat_fixed = 2;
      do_branch(32'h302);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #4;
         if (instr_valid) begin
            if (!got304) early = 1'b1;
            break;
         end
         if (imem_rvalid && rv_addr == 32'h304) got304 = 1'b1;
      end
      checks++;
      if (early) begin
         failures++;
         $display("FAIL split_early: got instr_valid=1 before word 0x304, want 0");
      end
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'hF000_F800 || instr_is32 !== 1'b1 || instr_addr !== 32'h302) begin
         failures++;
         $display("FAIL split_head: got v=%0b instr=%h is32=%0b addr=%h, want v=1 instr=f000f800 is32=1 addr=00000302",
                  instr_valid, instr, instr_is32, instr_addr);
      end
      push_stream(32'h302, 4);
      drain(60, 1'b0);
      checks++;
      if (exp_q.size() !== 0) begin
         failures++;
         $display("FAIL split_drain: got %0d pending, want 0", exp_q.size());
      end
      lat_fixed = 0;
   endtask

   task automatic test_backpressure();
      do_branch(32'h500);
      repeat (10) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #4;
         checks++;
         if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL bp_req: got imem_req=%0b, want 0", imem_req);
         end
      end
      checks++;
      if (instr_valid !== 1'b1 || instr_addr !== 32'h500 || instr !== {16'h0000, hw_at(32'h500)}) begin
         failures++;
         $display("FAIL bp_head: got v=%0b addr=%h instr=%h, want v=1 addr=00000500 instr=%h",
                  instr_valid, instr_addr, instr, {16'h0000, hw_at(32'h500)});
      end
      push_stream(32'h500, 10);
      drain(80, 1'b0);
      checks++;
      if (exp_q.size() !== 0) begin
         failures++;
         $display("FAIL bp_drain: got %0d pending, want 0", exp_q.size());
      end
   endtask

   task automatic test_branch_drop();
      lat_fixed = 3;
      do_branch(32'h400);
      wait_pend();
      do_branch(32'h102);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #4;
         if (imem_req) break;
      end
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
         failures++;
         $display("FAIL drop_refetch: got req=%0b addr=%h, want req=1 addr=00000100", imem_req, imem_addr);
      end
      lat_fixed = 0;
      push_stream(32'h102, 5);
      drain(60, 1'b0);
      checks++;
      if (exp_q.size() !== 0) begin
         failures++;
         $display("FAIL drop_drain: got %0d pending, want 0", exp_q.size());
      end
   endtask

   task automatic test_random();
      gnt_rand = 1'b1;
      lat_rand = 1'b1;
      do_branch(32'h600);
      push_stream(32'h600, 40);
      drain(800, 1'b1);
      checks++;
      if (exp_q.size() !== 0) begin
         failures++;
         $display("FAIL random_drain: got %0d pending, want 0", exp_q.size());
      end
      gnt_rand = 1'b0;
      lat_rand = 1'b0;
   endtask

   task automatic test_async_reset();
      lat_fixed = 5;
      do_branch(32'h700);
      wait_pend();
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({imem_req, imem_addr, instr_valid, instr, instr_is32, instr_addr, ld_pc, w_PC} !== 132'h0) begin
         failures++;
         $display("FAIL async_reset: got req=%0b addr=%h v=%0b instr=%h is32=%0b iaddr=%h ld=%0b wpc=%h, want all 0",
                  imem_req, imem_addr, instr_valid, instr, instr_is32, instr_addr, ld_pc, w_PC);
      end
      lat_fixed = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #4;
         if (imem_req) break;
      end
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         failures++;
         $display("FAIL reset_refetch: got req=%0b addr=%h, want req=1 addr=00000000", imem_req, imem_addr);
      end
      push_stream(32'h0, 4);
      drain(80, 1'b0);
      checks++;
      if (exp_q.size() !== 0) begin
         failures++;
         $display("FAIL reset_drain: got %0d pending, want 0", exp_q.size());
      end
   endtask

   initial begin
      rst = 1'b0;
      instr_ready   = 1'b0;
      branch_valid  = 1'b0;
      branch_target = 32'h0;
      mem[32'h0000_0000] = 32'h2001_4608;
      mem[32'h0000_0200] = 32'hF800_F000;
      mem[32'h0000_0300] = 32'hF000_2222;
      mem[32'h0000_0304] = 32'h3333_F800;
      mem[32'h0000_0604] = 32'hE800_1234;
      mem[32'h0000_0608] = 32'h5555_6666;
      test_reset();
      test_basic();
      test_bl();
      test_split();
      test_backpressure();
      test_branch_drop();
      test_random();
      test_async_reset();
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
